// File: rtl/resize_frame_ctrl_pkg.sv
// Shared constants, counter widths and the state encoding for the frame sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package resize_frame_ctrl_pkg;

  localparam int DEF_IN_WIDTH      = 1280;
  localparam int DEF_IN_HEIGHT     = 960;
  localparam int DEF_PAD_DIM       = 34;
  localparam int DEF_FLUSH_LEN     = 1280;
  localparam int DEF_DRAIN_TIMEOUT = 4096;

  localparam int IN_PIXELS  = DEF_IN_WIDTH * DEF_IN_HEIGHT;
  localparam int OUT_PIXELS = DEF_PAD_DIM * DEF_PAD_DIM;

  localparam int PIX_W       = 12;
  localparam int IN_CNT_W    = 21;
  localparam int OUT_CNT_W   = 11;
  localparam int TMR_W       = 13;
  localparam int FLUSH_CNT_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SOF = 3'd1,
    ST_FEED     = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_RZ_RESET = 3'd5
  } state_t;

endpackage

// File: rtl/resize_frame_ctrl_if.sv
// Pixel-path bundle between camera, frame sequencer and resizer.
// Latency: n/a (wiring only).
// Backpressure: none; camera and resizer are free-running valid-only streams.
// Signals: cam_sof/cam_valid/cam_pixel from the camera, rz_rst/rz_valid_in/rz_pixel_in
// to the resizer, rz_valid_out back from the resizer. master = sequencer, slave = environment.
interface resize_frame_ctrl_if;
  import resize_frame_ctrl_pkg::*;

  logic             cam_sof;
  logic             cam_valid;
  logic [PIX_W-1:0] cam_pixel;
  logic             rz_rst;
  logic             rz_valid_in;
  logic [PIX_W-1:0] rz_pixel_in;
  logic             rz_valid_out;

  modport master (
    input  cam_sof, cam_valid, cam_pixel, rz_valid_out,
    output rz_rst, rz_valid_in, rz_pixel_in
  );

  modport slave (
    output cam_sof, cam_valid, cam_pixel, rz_valid_out,
    input  rz_rst, rz_valid_in, rz_pixel_in
  );

endinterface

// File: rtl/resize_frame_ctrl.sv
// Frame sequencer: gates one camera frame into the resizer, flushes it, counts outputs.
// Latency: 1 cycle camera->resizer pixel pass-through; all outputs registered except o_busy.
// Backpressure: none; the camera cannot be stalled, so extra/late pixels are dropped.
// Ports: i_clk, i_rst (sync, active-high), i_capture_req / i_abort pulses from the host,
// io_bus (camera + resizer pixel path), o_busy, o_frame_done pulse, sticky o_err_short /
// o_err_timeout, o_out_count (resizer outputs seen in the current capture).
module resize_frame_ctrl
  import resize_frame_ctrl_pkg::*;
#(
  parameter int IN_WIDTH      = DEF_IN_WIDTH,
  parameter int IN_HEIGHT     = DEF_IN_HEIGHT,
  parameter int PAD_DIM       = DEF_PAD_DIM,
  parameter int FLUSH_LEN     = DEF_FLUSH_LEN,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_capture_req,
  input  logic                 i_abort,
  resize_frame_ctrl_if.master  io_bus,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_err_short,
  output logic                 o_err_timeout,
  output logic [OUT_CNT_W-1:0] o_out_count
);

  localparam logic [IN_CNT_W-1:0]    LP_IN_LAST    = IN_CNT_W'(IN_WIDTH * IN_HEIGHT - 1);
  localparam logic [OUT_CNT_W-1:0]   LP_OUT_PIX    = OUT_CNT_W'(PAD_DIM * PAD_DIM);
  localparam logic [FLUSH_CNT_W-1:0] LP_FLUSH_LAST = FLUSH_CNT_W'(FLUSH_LEN - 1);
  localparam logic [TMR_W-1:0]       LP_TIMEOUT    = TMR_W'(DRAIN_TIMEOUT);

  state_t                 r_state;
  state_t                 r_ret_state;
  logic [IN_CNT_W-1:0]    r_in_count;
  logic [FLUSH_CNT_W-1:0] r_flush_count;
  logic [TMR_W-1:0]       r_timer;
  logic [OUT_CNT_W-1:0]   r_out_count;
  logic                   r_rst_cnt;
  logic                   r_rz_rst;
  logic                   r_rz_valid_in;
  logic [PIX_W-1:0]       r_rz_pixel_in;
  logic                   r_frame_done;
  logic                   r_err_short;
  logic                   r_err_timeout;

  logic                   w_count_out;
  logic                   w_to_reset;
  state_t                 w_reset_ret;
  logic                   w_early_sof;
  logic                   w_timeout;

  // The resizer may emit while still being fed or flushed, so outputs are
  // counted from the first FEED cycle; saturated counts ignore extra pulses.
  assign w_count_out = io_bus.rz_valid_out &&
                       (r_state == ST_FEED || r_state == ST_FLUSH || r_state == ST_DRAIN) &&
                       (r_out_count != LP_OUT_PIX);

  // Every route into RZ_RESET, in priority order: abort beats early SOF and timeout.
  always_comb begin
    w_to_reset  = 1'b0;
    w_reset_ret = ST_IDLE;
    w_early_sof = 1'b0;
    w_timeout   = 1'b0;
    if (i_abort && r_state != ST_IDLE) begin
      w_to_reset = 1'b1;
    end else if (r_state == ST_FEED && io_bus.cam_sof && r_in_count < LP_IN_LAST) begin
      w_to_reset  = 1'b1;
      w_early_sof = 1'b1;
      w_reset_ret = ST_WAIT_SOF;  // retry on the next frame automatically
    end else if (r_state == ST_DRAIN && r_out_count != LP_OUT_PIX && r_timer == LP_TIMEOUT) begin
      w_to_reset = 1'b1;
      w_timeout  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_ret_state   <= ST_IDLE;
      r_in_count    <= '0;
      r_flush_count <= '0;
      r_timer       <= '0;
      r_out_count   <= '0;
      r_rst_cnt     <= 1'b0;
      r_rz_rst      <= 1'b1;
      r_rz_valid_in <= 1'b0;
      r_rz_pixel_in <= '0;
      r_frame_done  <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_rz_rst     <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_count_out) r_out_count <= r_out_count + 1'b1;

      if (w_to_reset) begin
        r_state       <= ST_RZ_RESET;
        r_ret_state   <= w_reset_ret;
        r_rst_cnt     <= 1'b0;
        r_rz_rst      <= 1'b1;
        r_rz_valid_in <= 1'b0;
        r_rz_pixel_in <= '0;
        if (w_early_sof) r_err_short   <= 1'b1;
        if (w_timeout)   r_err_timeout <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_rz_valid_in <= 1'b0;
            r_rz_pixel_in <= '0;
            if (i_capture_req && !i_abort) begin
              r_state       <= ST_WAIT_SOF;
              r_err_short   <= 1'b0;
              r_err_timeout <= 1'b0;
              r_out_count   <= '0;
            end
          end
          ST_WAIT_SOF: begin
            // Only a pixel that coincides with SOF gets through; it is pixel 0.
            r_rz_valid_in <= io_bus.cam_sof && io_bus.cam_valid;
            r_rz_pixel_in <= io_bus.cam_pixel;
            if (io_bus.cam_sof) begin
              r_state     <= ST_FEED;
              r_in_count  <= {{(IN_CNT_W-1){1'b0}}, io_bus.cam_valid};
              r_out_count <= '0;
            end
          end
          ST_FEED: begin
            r_rz_valid_in <= io_bus.cam_valid;
            r_rz_pixel_in <= io_bus.cam_pixel;
            if (io_bus.cam_valid) begin
              r_in_count <= r_in_count + 1'b1;
              if (r_in_count == LP_IN_LAST) begin
                r_state       <= ST_FLUSH;
                r_flush_count <= '0;
              end
            end
          end
          ST_FLUSH: begin
            // Zero pixels push the last line out of the resizer's line delay.
            r_rz_valid_in <= 1'b1;
            r_rz_pixel_in <= '0;
            r_flush_count <= r_flush_count + 1'b1;
            if (r_flush_count == LP_FLUSH_LAST) begin
              r_state <= ST_DRAIN;
              r_timer <= '0;
            end
          end
          ST_DRAIN: begin
            r_rz_valid_in <= 1'b0;
            r_rz_pixel_in <= '0;
            if (r_out_count == LP_OUT_PIX) begin
              r_frame_done <= 1'b1;
              r_state      <= ST_IDLE;
            end else if (io_bus.rz_valid_out) begin
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          ST_RZ_RESET: begin
            r_rz_valid_in <= 1'b0;
            r_rz_pixel_in <= '0;
            if (r_rst_cnt) begin
              r_state <= r_ret_state;
            end else begin
              r_rst_cnt <= 1'b1;
              r_rz_rst  <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_busy             = (r_state != ST_IDLE);
  assign o_frame_done       = r_frame_done;
  assign o_err_short        = r_err_short;
  assign o_err_timeout      = r_err_timeout;
  assign o_out_count        = r_out_count;
  assign io_bus.rz_rst      = r_rz_rst;
  assign io_bus.rz_valid_in = r_rz_valid_in;
  assign io_bus.rz_pixel_in = r_rz_pixel_in;

endmodule

// File: tb/tb_resize_frame_ctrl.sv
// Bench for the frame sequencer on a scaled-down 16x8 -> 6x6 geometry.
// Latency: n/a.
// Backpressure: n/a.
module tb_resize_frame_ctrl;

  localparam int TW = 16, TH = 8, TPD = 6, TFL = 16, TDT = 64;
  localparam int TIN = TW * TH;
  localparam int TOUT = TPD * TPD;

  logic        clk = 1'b0;
  logic        rst, capture_req, abort;
  logic        busy, frame_done, err_short, err_timeout;
  logic [10:0] out_count;

  resize_frame_ctrl_if bus ();

  resize_frame_ctrl #(
    .IN_WIDTH(TW), .IN_HEIGHT(TH), .PAD_DIM(TPD), .FLUSH_LEN(TFL), .DRAIN_TIMEOUT(TDT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_capture_req(capture_req), .i_abort(abort),
    .io_bus(bus.master), .o_busy(busy), .o_frame_done(frame_done),
    .o_err_short(err_short), .o_err_timeout(err_timeout), .o_out_count(out_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] pix;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   n_vin = 0, n_flush = 0, n_done = 0, last_vin_cyc = 0;
  int   rz_budget = 0, arm_base = 0;
  bit   rz_enable = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one camera cycle; forwarded pixels are expected on the resizer side next cycle.
  task automatic drive_px(input bit sof, input bit vld, input logic [11:0] px, input bit fwd);
    bus.cam_sof   = sof;
    bus.cam_valid = vld;
    bus.cam_pixel = px;
    if (vld && fwd) q.push_back('{px, cyc + 1});
    tick();
    bus.cam_sof   = 1'b0;
    bus.cam_valid = 1'b0;
  endtask

  // sof_mode: 0 = continuation, 1 = SOF with first pixel, 2 = SOF one cycle ahead.
  task automatic send_frame(input int npx, input int gap, input int sof_mode);
    logic [11:0] p;
    if (sof_mode == 2) drive_px(1'b1, 1'b0, 12'h0, 1'b0);
    for (int i = 0; i < npx; i++) begin
      p = 12'($urandom);
      drive_px(i == 0 && sof_mode == 1, 1'b1, p, 1'b1);
      for (int g = 0; g < gap; g++) drive_px(1'b0, 1'b0, 12'($urandom), 1'b0);
    end
  endtask

  // Resizer side scoreboard: frame pixels in order with 1-cycle latency, then zeros.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_done) n_done++;
      if (bus.rz_valid_in) begin
        n_vin++;
        last_vin_cyc = cyc;
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("fwd_pixel", 32'(bus.rz_pixel_in), 32'(e.pix));
          chk("fwd_latency", cyc, e.due);
        end else begin
          n_flush++;
          chk("flush_pixel", 32'(bus.rz_pixel_in), 0);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        void'(q.pop_front());
        chk("fwd_missing", 32'(bus.rz_valid_in), 1);
      end
    end
  endtask

  // Resizer output model: once armed by a fed pixel, emits rz_budget pulses at random spacing.
  task automatic rz_model();
    int gap = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rz_enable && n_vin > arm_base && rz_budget > 0 &&
          (gap >= 6 || $urandom_range(0, 3) == 0)) begin
        bus.rz_valid_out = 1'b1;
        rz_budget--;
        gap = 0;
      end else begin
        bus.rz_valid_out = 1'b0;
        gap++;
      end
    end
  endtask

  task automatic start_capture(input bit en, input int budget);
    rz_enable   = en;
    arm_base    = n_vin;
    rz_budget   = budget;
    capture_req = 1'b1;
    tick();
    capture_req = 1'b0;
    chk("busy_after_req", 32'(busy), 1);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy && k < limit) begin
      tick();
      k++;
    end
    chk("idle_reached", 32'(busy), 0);
  endtask

  initial begin
    int vin0, fl0, d0, k, delta;
    rst = 1'b1; capture_req = 1'b0; abort = 1'b0;
    bus.cam_sof = 1'b0; bus.cam_valid = 1'b0; bus.cam_pixel = '0; bus.rz_valid_out = 1'b0;
    fork
      monitor();
      rz_model();
    join_none
    tick(); tick();
    chk("rst_rz_rst", 32'(bus.rz_rst), 1);
    chk("rst_valid_in", 32'(bus.rz_valid_in), 0);
    chk("rst_pixel_in", 32'(bus.rz_pixel_in), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_errs", 32'({frame_done, err_short, err_timeout}), 0);
    rst = 1'b0;
    tick();
    chk("idle_rz_rst", 32'(bus.rz_rst), 0);

    // Nominal frame, gap-free, SOF with first pixel; extra resizer pulses test saturation.
    vin0 = n_vin; fl0 = n_flush; d0 = n_done;
    start_capture(1'b1, TOUT + 4);
    send_frame(TIN, 0, 1);
    wait_idle(2000);
    repeat (3) tick();
    chk("nom_vin", n_vin - vin0, TIN + TFL);
    chk("nom_flush", n_flush - fl0, TFL);
    chk("nom_done", n_done - d0, 1);
    chk("nom_out_count", 32'(out_count), TOUT);
    chk("nom_errs", 32'({err_short, err_timeout}), 0);

    // Resizer pulses while IDLE are ignored.
    rz_enable = 1'b1; arm_base = n_vin - 1; rz_budget = 10;
    repeat (60) tick();
    chk("idle_ignore_count", 32'(out_count), TOUT);
    rz_enable = 1'b0;

    // Sparse camera (every 3rd cycle), SOF ahead of the first pixel.
    vin0 = n_vin; fl0 = n_flush; d0 = n_done;
    start_capture(1'b1, TOUT);
    send_frame(TIN, 2, 2);
    wait_idle(2000);
    repeat (3) tick();
    chk("sparse_vin", n_vin - vin0, TIN + TFL);
    chk("sparse_flush", n_flush - fl0, TFL);
    chk("sparse_done", n_done - d0, 1);
    chk("sparse_out_count", 32'(out_count), TOUT);

    // Short frame: early SOF after 50 pixels, then automatic retry on the next frame.
    vin0 = n_vin; fl0 = n_flush; d0 = n_done;
    start_capture(1'b0, 0);
    send_frame(50, 0, 1);
    drive_px(1'b1, 1'b1, 12'hABC, 1'b0);
    chk("short_err", 32'(err_short), 1);
    chk("short_rz_rst1", 32'(bus.rz_rst), 1);
    chk("short_vin_low", 32'(bus.rz_valid_in), 0);
    tick();
    chk("short_rz_rst2", 32'(bus.rz_rst), 1);
    tick();
    chk("short_rz_rst_end", 32'(bus.rz_rst), 0);
    chk("short_busy_wait_sof", 32'(busy), 1);
    rz_enable = 1'b1; arm_base = n_vin; rz_budget = TOUT;
    send_frame(TIN, 0, 1);
    wait_idle(2000);
    repeat (3) tick();
    chk("short_vin", n_vin - vin0, 50 + TIN + TFL);
    chk("short_done", n_done - d0, 1);
    chk("short_err_sticky", 32'(err_short), 1);
    chk("short_no_tmo", 32'(err_timeout), 0);
    chk("short_out_count", 32'(out_count), TOUT);

    // Drain timeout: resizer returns only 20 pixels.
    d0 = n_done;
    start_capture(1'b1, 20);
    chk("req_clears_short", 32'(err_short), 0);
    send_frame(TIN, 0, 1);
    k = 0;
    while (!err_timeout && k < 600) begin
      tick();
      k++;
    end
    chk("tmo_seen", 32'(err_timeout), 1);
    delta = cyc - last_vin_cyc;
    chk("tmo_delay_min", 32'(delta >= TDT), 1);
    chk("tmo_delay_max", 32'(delta <= TDT + 2), 1);
    chk("tmo_rz_rst1", 32'(bus.rz_rst), 1);
    tick();
    chk("tmo_rz_rst2", 32'(bus.rz_rst), 1);
    tick();
    chk("tmo_rz_rst_end", 32'(bus.rz_rst), 0);
    chk("tmo_idle", 32'(busy), 0);
    chk("tmo_no_done", n_done - d0, 0);
    chk("tmo_out_count", 32'(out_count), 20);

    // Abort during FLUSH after three flush cycles.
    fl0 = n_flush; d0 = n_done;
    start_capture(1'b1, TOUT);
    chk("req_clears_tmo", 32'(err_timeout), 0);
    send_frame(TIN, 0, 1);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_vin_drop", 32'(bus.rz_valid_in), 0);
    chk("abort_rz_rst1", 32'(bus.rz_rst), 1);
    tick();
    chk("abort_rz_rst2", 32'(bus.rz_rst), 1);
    tick();
    chk("abort_rz_rst_end", 32'(bus.rz_rst), 0);
    chk("abort_idle", 32'(busy), 0);
    chk("abort_flush_cnt", n_flush - fl0, 3);
    chk("abort_no_flags", 32'({err_short, err_timeout}), 0);
    chk("abort_no_done", n_done - d0, 0);

    // capture_req with abort while IDLE: abort wins.
    repeat (4) tick();
    capture_req = 1'b1; abort = 1'b1;
    tick();
    capture_req = 1'b0; abort = 1'b0;
    chk("req_abort_idle", 32'(busy), 0);

    // capture_req mid-FEED is ignored; then synchronous reset mid-FEED.
    vin0 = n_vin;
    start_capture(1'b1, TOUT);
    send_frame(10, 0, 1);
    capture_req = 1'b1;
    drive_px(1'b0, 1'b1, 12'h5A5, 1'b1);
    capture_req = 1'b0;
    chk("feed_req_busy", 32'(busy), 1);
    send_frame(20, 0, 0);
    repeat (2) tick();
    chk("feed_req_vin", n_vin - vin0, 31);
    rz_enable = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_rz_rst", 32'(bus.rz_rst), 1);
    chk("midrst_valid_in", 32'(bus.rz_valid_in), 0);
    chk("midrst_pixel_in", 32'(bus.rz_pixel_in), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_out_count", 32'(out_count), 0);
    chk("midrst_flags", 32'({frame_done, err_short, err_timeout}), 0);
    rst = 1'b0;
    tick();
    chk("midrst_release", 32'(bus.rz_rst), 0);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
